// File: rtl/mem_bus_master_if.sv
// mem_bus_master_if
// Request/response handshake plus memory strobe/address bundle for mem_bus_master.
// Ports (signals):
//   req_valid, req_we, req_addr[25:0], req_wdata[31:0], req_len[1:0] : request from client
//   req_ready                                                      : block idle, accepts request
//   rdata[31:0], rdata_valid, rdata_last                           : read beats back to client
//   done, err                                                      : completion pulse, write-length error
//   mem_read, mem_write, mem_addr[25:0]                            : memory strobes and word address
// The shared memory data bus is bidirectional and lives on the module as a plain inout.
interface mem_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [25:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_len;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        rdata_last;
    logic        done;
    logic        err;
    logic        mem_read;
    logic        mem_write;
    logic [25:0] mem_addr;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_len,
        output req_ready, rdata, rdata_valid, rdata_last, done, err,
               mem_read, mem_write, mem_addr
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_len,
        input  req_ready, rdata, rdata_valid, rdata_last, done, err,
               mem_read, mem_write, mem_addr
    );
endinterface

// File: rtl/mem_bus_master.sv
// mem_bus_master
// Single-outstanding memory bus master: single-word writes and 1..BURST_MAX word
// read bursts over a shared bidirectional data bus with a one-cycle read latency.
// Ports:
//   clk      : system clock, all state changes on the rising edge
//   rst      : synchronous active-high reset
//   bus      : mem_bus_master_if.master (request handshake, read beats, done/err,
//              memory strobes and address)
//   mem_data : shared 32-bit memory data bus, driven only during the write cycle
module mem_bus_master #(
    parameter int BURST_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_master_if.master bus,
    inout  wire [31:0]       mem_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        TURN = 2'd3
    } state_t;

    localparam logic [1:0] LEN_MAX = 2'(BURST_MAX - 1);

    // Limit a requested burst length (minus one) to what this instance supports.
    function automatic logic [1:0] clamp_len(input logic [1:0] len);
        logic [1:0] len_c;
        if (len > LEN_MAX) begin
            len_c = LEN_MAX;
        end else begin
            len_c = len;
        end
        return len_c;
    endfunction

    state_t      state_r;
    state_t      state_nx;
    logic        ready_r;
    logic        mem_read_r;
    logic        mem_write_r;
    logic [25:0] mem_addr_r;
    logic [31:0] wdata_r;
    logic [1:0]  len_r;
    logic        err_pend_r;
    logic [1:0]  issue_cnt_r;
    logic [1:0]  beat_cnt_r;
    logic        drain_r;
    logic [31:0] rdata_r;
    logic        rdata_valid_r;
    logic        rdata_last_r;
    logic        done_r;
    logic        err_r;

    logic        accept_s;
    logic        capture_s;
    logic        mem_read_nx;
    logic        mem_write_nx;
    logic [25:0] mem_addr_nx;
    logic [1:0]  issue_cnt_nx;
    logic        drain_nx;

    assign accept_s = ready_r && bus.req_valid;

    // Next-state and next-strobe decode. Strobes and address are registered from
    // these so they line up with the state they belong to.
    always_comb begin
        state_nx     = state_r;
        mem_read_nx  = 1'b0;
        mem_write_nx = 1'b0;
        mem_addr_nx  = mem_addr_r;
        issue_cnt_nx = issue_cnt_r;
        drain_nx     = drain_r;
        capture_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    issue_cnt_nx = 2'd0;
                    drain_nx     = 1'b0;
                    mem_addr_nx  = bus.req_addr;
                    if (bus.req_we) begin
                        state_nx     = WR;
                        mem_write_nx = 1'b1;
                    end else begin
                        state_nx     = RD;
                        mem_read_nx  = 1'b1;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            WR: begin
                state_nx = TURN;
            end
            RD: begin
                // Data for the previous cycle's address is on the bus in every RD
                // cycle except the first one.
                capture_s = (issue_cnt_r != 2'd0) || drain_r;
                if (drain_r) begin
                    state_nx = TURN;
                    drain_nx = 1'b0;
                end else begin
                    mem_read_nx = 1'b1;
                    if (issue_cnt_r == len_r) begin
                        // Last address issued: one more strobed cycle, address held,
                        // to collect the final word.
                        drain_nx = 1'b1;
                    end else begin
                        issue_cnt_nx = issue_cnt_r + 2'd1;
                        mem_addr_nx  = mem_addr_r + 26'd1;
                    end
                end
            end
            TURN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Registered strobes, address, issue/drain tracking and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r     <= 1'b1;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem_addr_r  <= 26'd0;
            issue_cnt_r <= 2'd0;
            drain_r     <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            ready_r     <= (state_nx == IDLE);
            mem_read_r  <= mem_read_nx;
            mem_write_r <= mem_write_nx;
            mem_addr_r  <= mem_addr_nx;
            issue_cnt_r <= issue_cnt_nx;
            drain_r     <= drain_nx;
            done_r      <= (state_nx == TURN);
            err_r       <= (state_nx == TURN) && err_pend_r;
        end
    end

    // Request capture and read-beat datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdata_r       <= 32'd0;
            len_r         <= 2'd0;
            err_pend_r    <= 1'b0;
            beat_cnt_r    <= 2'd0;
            rdata_r       <= 32'd0;
            rdata_valid_r <= 1'b0;
            rdata_last_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                wdata_r    <= bus.req_wdata;
                len_r      <= clamp_len(bus.req_len);
                // A write carries one word only; any length hint flags an error.
                err_pend_r <= bus.req_we && (bus.req_len != 2'd0);
                beat_cnt_r <= 2'd0;
            end else if (capture_s) begin
                rdata_r    <= mem_data;
                beat_cnt_r <= beat_cnt_r + 2'd1;
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
            rdata_valid_r <= capture_s;
            rdata_last_r  <= capture_s && (beat_cnt_r == len_r);
        end
    end

    // The write strobe register doubles as the bus output enable, so the data bus
    // is driven exactly in the WR cycle.
    assign mem_data = mem_write_r ? wdata_r : 32'bz;

    assign bus.req_ready   = ready_r;
    assign bus.mem_read    = mem_read_r;
    assign bus.mem_write   = mem_write_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.rdata       = rdata_r;
    assign bus.rdata_valid = rdata_valid_r;
    assign bus.rdata_last  = rdata_last_r;
    assign bus.done        = done_r;
    assign bus.err         = err_r;

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master
// Scoreboard bench for mem_bus_master: a memory slave with one-cycle read latency,
// a request driver that pushes expected writes/beats/completions (with the cycle
// they must appear in) computed from a reference memory, and a monitor thread that
// pops and compares whenever the DUT presents a strobe, beat or done.
module tb_mem_bus_master;
    localparam int BM = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_bus_master_if bus();
    wire  [31:0] mem_data;
    logic [31:0] rd_q;
    logic        rd_ok;

    assign mem_data = (bus.mem_read && rd_ok) ? rd_q : 32'bz;

    mem_bus_master #(.BURST_MAX(BM)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mem_data (mem_data)
    );

    typedef struct { int cyc; logic [31:0] data; logic last; } beat_t;
    typedef struct { int cyc; logic [25:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int cyc; logic err; logic is_rd; } done_t;

    beat_t beat_q[$];
    wr_t   wr_q[$];
    done_t done_q[$];

    logic [31:0] mem     [logic [25:0]];
    logic [31:0] ref_mem [logic [25:0]];

    int cyc;
    int rd_cycles;
    int n_checks;
    int n_pass;
    int last_done_cyc;

    function automatic logic [31:0] init_word(input logic [25:0] a);
        return {6'h2A, a} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [25:0] a);
        if (mem.exists(a)) return mem[a];
        else return init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [25:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        else return init_word(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic preload(input logic [25:0] a, input logic [31:0] d);
        mem[a]     = d;
        ref_mem[a] = d;
    endtask

    task automatic monitor_step();
        beat_t b;
        wr_t   w;
        done_t d;
        bit    hit;
        while (beat_q.size() > 0 && beat_q[0].cyc < cyc) begin
            chk("beat_missing_cycle", cyc, beat_q[0].cyc);
            void'(beat_q.pop_front());
        end
        while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
            chk("done_missing_cycle", cyc, done_q[0].cyc);
            void'(done_q.pop_front());
        end
        while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
            chk("write_missing_cycle", cyc, wr_q[0].cyc);
            void'(wr_q.pop_front());
        end
        if (bus.rdata_valid) begin
            hit = (beat_q.size() > 0) && (beat_q[0].cyc == cyc);
            chk("beat_expected", hit, 1'b1);
            if (hit) begin
                b = beat_q.pop_front();
                chk("rdata", bus.rdata, b.data);
                chk("rdata_last", bus.rdata_last, b.last);
            end
        end
        if (bus.done) begin
            hit = (done_q.size() > 0) && (done_q[0].cyc == cyc);
            chk("done_expected", hit, 1'b1);
            if (hit) begin
                d = done_q.pop_front();
                chk("err", bus.err, d.err);
                chk("done_with_last_beat", {bus.rdata_valid, bus.rdata_last}, {d.is_rd, d.is_rd});
            end
        end
        if (bus.mem_write) begin
            hit = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
            chk("write_expected", hit, 1'b1);
            if (hit) begin
                w = wr_q.pop_front();
                chk("wr_addr", bus.mem_addr, w.addr);
                chk("wr_data", mem_data, w.data);
            end
        end
        if (bus.mem_read || bus.mem_write) begin
            chk("strobe_exclusive", bus.mem_read & bus.mem_write, 1'b0);
        end
    endtask

    // Presents a request (at a negedge) and waits for acceptance; on return the
    // caller is at the negedge after the accepting edge with req_valid still high.
    task automatic issue(input logic we, input logic [25:0] addr, input logic [31:0] wd,
                         input logic [1:0] len, input bit track);
        int          waited;
        int          start;
        int          c;
        int          n;
        int          exp_acc;
        logic [25:0] a;
        beat_t       b;
        wr_t         w;
        done_t       d;
        waited = 0;
        start  = cyc;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_len   = len;
        while (!bus.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            chk("accept_timeout_waited", waited, 0);
            bus.req_valid = 1'b0;
            return;
        end
        c = cyc;
        exp_acc = (last_done_cyc + 1 > start) ? last_done_cyc + 1 : start;
        chk("accept_cycle", c, exp_acc);
        if (track) begin
            if (we) begin
                w.cyc = c + 1; w.addr = addr; w.data = wd;
                wr_q.push_back(w);
                ref_mem[addr] = wd;
                d.cyc = c + 2; d.err = (len != 2'd0); d.is_rd = 1'b0;
                done_q.push_back(d);
                last_done_cyc = c + 2;
            end else begin
                n = ((int'(len) > BM - 1) ? BM - 1 : int'(len)) + 1;
                a = addr;
                for (int j = 0; j < n; j++) begin
                    b.cyc = c + 3 + j; b.data = ref_rd(a); b.last = (j == n - 1);
                    beat_q.push_back(b);
                    a = a + 26'd1;
                end
                d.cyc = c + n + 2; d.err = 1'b0; d.is_rd = 1'b1;
                done_q.push_back(d);
                last_done_cyc = c + n + 2;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        bus.req_valid = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    initial begin
        int          rd0;
        int          gap;
        logic [25:0] ra;
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        rd_cycles = 0;
        rd_q     = 32'd0;
        rd_ok    = 1'b0;
        last_done_cyc = -10;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 26'd0;
        bus.req_wdata = 32'd0;
        bus.req_len   = 2'd0;
        rst = 1'b1;

        fork
            forever begin
                @(posedge clk);
                cyc <= cyc + 1;
                if (bus.mem_write) mem[bus.mem_addr] = mem_data;
                if (bus.mem_read) rd_cycles <= rd_cycles + 1;
                rd_q  <= mem_rd(bus.mem_addr);
                rd_ok <= bus.mem_read;
            end
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.req_ready, 1'b1);
        chk("rst_strobes", {bus.mem_read, bus.mem_write}, 2'b00);
        chk("rst_mem_addr", bus.mem_addr, 26'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_flags", {bus.rdata_valid, bus.rdata_last, bus.done, bus.err}, 4'b0000);
        rst = 1'b0;
        @(negedge clk);

        // Single write, memory updated.
        issue(1'b1, 26'h0000010, 32'hDEADBEEF, 2'd0, 1'b1);
        idle(3);
        chk("mem_word_0x10", mem_rd(26'h0000010), 32'hDEADBEEF);

        // Four-beat read; strobe held for N+1 cycles.
        for (int i = 0; i < 4; i++) preload(26'h10 + 26'(i), 32'hA0 + 32'(i));
        rd0 = rd_cycles;
        issue(1'b0, 26'h0000010, 32'd0, 2'd3, 1'b1);
        idle(7);
        chk("read_strobe_cycles", rd_cycles - rd0, 5);

        // Burst wrapping past the top of the address space.
        preload(26'h3FFFFFF, 32'hFEED0001);
        preload(26'h0000000, 32'hFEED0000);
        issue(1'b0, 26'h3FFFFFF, 32'd0, 2'd1, 1'b1);
        idle(5);

        // Write with a length hint: single write plus err.
        issue(1'b1, 26'h0000020, 32'h12345678, 2'd2, 1'b1);
        idle(3);

        // Reset during the second cycle of a four-beat read: aborted silently.
        issue(1'b0, 26'h0000010, 32'd0, 2'd3, 1'b0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_strobes", {bus.mem_read, bus.mem_write}, 2'b00);
        chk("abort_beat_done", {bus.rdata_valid, bus.done}, 2'b00);
        rst = 1'b0;
        last_done_cyc = -10;
        @(negedge clk);
        chk("ready_after_reset", bus.req_ready, 1'b1);
        idle(6);

        // Back-to-back write then read of the same word, request held high.
        issue(1'b1, 26'h0000030, 32'hCAFEF00D, 2'd0, 1'b1);
        issue(1'b0, 26'h0000030, 32'd0, 2'd0, 1'b1);
        idle(5);

        // Randomized traffic against the reference memory.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) ra = 26'h3FFFFFC + 26'($urandom_range(0, 3));
            else ra = 26'($urandom_range(0, 31));
            issue(1'($urandom_range(0, 1)), ra, $urandom, 2'($urandom_range(0, 3)), 1'b1);
            gap = $urandom_range(0, 2);
            if (gap != 0) idle(gap);
        end
        idle(12);

        chk("beat_queue_drained", beat_q.size(), 0);
        chk("done_queue_drained", done_q.size(), 0);
        chk("write_queue_drained", wr_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_master.md
MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 Parameter: BURST_MAX, default 4, maximum read burst length in words (legal 1..4, so REQ_LEN fits 2 bits).
REQ-002 Port: CLK  input  1  system clock; all state changes on rising edge.
REQ-003 Port: RST  input  1  reset; synchronous, active-high.
REQ-004 Port: REQ_VALID  input  1  request present.
REQ-005 Port: REQ_READY  output  1  block accepts request this cycle.
REQ-006 Port: REQ_WE  input  1  1=write, 0=read.
REQ-007 Port: REQ_ADDR  input  26  start word address.
REQ-008 Port: REQ_WDATA  input  32  write data.
REQ-009 Port: REQ_LEN  input  2  read burst length minus 1.
REQ-010 Port: RDATA  output  32  read data beat.
REQ-011 Port: RDATA_VALID  output  1  RDATA valid; one cycle per beat, no backpressure.
REQ-012 Port: RDATA_LAST  output  1  final beat of burst, qualified by RDATA_VALID.
REQ-013 Port: DONE  output  1  one-cycle pulse at completion of each request.
REQ-014 Port: ERR  output  1  one-cycle pulse with DONE when write had REQ_LEN!=0.
REQ-015 Port: MEM_READ / MEM_WRITE  output  1 each  memory strobes.
REQ-016 Port: MEM_ADDR  output  26  memory word address.
REQ-017 Port: MEM_DATA  inout  32  shared memory data bus.

Function
REQ-018 States SHALL be IDLE, WR, RD, TURN; REQ_READY SHALL be 1 only in IDLE.
REQ-019 Handshake: request accepted on rising edge with REQ_VALID=1 and REQ_READY=1; REQ_WE, REQ_ADDR, REQ_WDATA and REQ_LEN captured there; REQ_VALID outside IDLE ignored.
REQ-020 IDLE: MEM_READ=0, MEM_WRITE=0, MEM_DATA high-Z; accept -> WR (REQ_WE=1) or RD (REQ_WE=0).
REQ-021 WR, exactly one cycle: MEM_WRITE=1, MEM_READ=0, MEM_ADDR=captured addr, MEM_DATA driven with captured wdata; next state TURN.
REQ-022 Write with REQ_LEN!=0: single write only, ERR pulsed with DONE.
REQ-023 MEM_DATA SHALL be driven only in WR; high-Z in every other state and during reset.
REQ-024 RD: MEM_READ=1 and MEM_WRITE=0 continuously for N+1 cycles, N=REQ_LEN+1; MEM_ADDR=A+k in RD cycle k (k=0..N-1), held at A+N-1 in drain cycle N.
REQ-025 Memory returns the word for the previous cycle's address; at the end of RD cycles 1..N, MEM_DATA SHALL be registered into RDATA, beat j=cycle-1.
REQ-026 RDATA_VALID SHALL be 1 in the cycle after each capture, so beats appear on N consecutive cycles, first beat 2 cycles after first RD cycle; RDATA_LAST with beat N-1.
REQ-027 After RD cycle N -> TURN; TURN lasts one cycle with strobes 0, MEM_DATA high-Z, DONE=1 (coincides with last RDATA_VALID for reads), then IDLE.
REQ-028 Address increment SHALL be modulo 2^26: burst from 0x3FFFFFF continues at 0x0000000.
REQ-029 Beat/issue counters 2 bits wide; REQ_LEN>BURST_MAX-1 SHALL be clamped to BURST_MAX-1.
REQ-030 MEM_READ and MEM_WRITE SHALL never both be 1.
REQ-031 Latency: write accept->DONE 2 cycles; read accept->DONE N+2 cycles; back-to-back request earliest accepted the cycle after TURN.

Reset
REQ-032 RST=1 at rising edge SHALL force state IDLE, MEM_READ=0, MEM_WRITE=0, MEM_ADDR=0, MEM_DATA high-Z, RDATA=0, RDATA_VALID=0, RDATA_LAST=0, DONE=0, ERR=0, counters 0.
REQ-033 Reset mid-burst or mid-write SHALL abort with no further strobe, beat or DONE; REQ_READY=1 the first cycle after RST deasserts.
REQ-034 Memory reset is separate and not driven by this block.

Verification
REQ-035 Write 0xDEADBEEF to 0x0000010 -> one cycle MEM_WRITE=1 with MEM_ADDR=0x0000010, DONE 2 cycles after accept, memory word updated.
REQ-036 Read LEN=3 from 0x0000010 with mem[0x10..0x13]=0xA0..0xA3 -> MEM_READ high 5 cycles, RDATA_VALID 4 consecutive cycles 0xA0,0xA1,0xA2,0xA3, RDATA_LAST and DONE on 4th.
REQ-037 Read LEN=1 from 0x3FFFFFF -> MEM_ADDR 0x3FFFFFF then 0x0000000, beats mem[0x3FFFFFF], mem[0x0].
REQ-038 Write with REQ_LEN=2 -> single write, DONE and ERR pulse together.
REQ-039 RST asserted during 2nd RD cycle of LEN=3 read -> strobes 0 next cycle, no RDATA_VALID/DONE, REQ_READY=1 after release.
REQ-040 Back-to-back write then read held on REQ_VALID -> second accepted cycle after TURN; MEM_DATA high-Z at least one cycle between write and read strobes.
